// File: rtl/ram_sdp_init.sv
// ram_sdp_init -- simple-dual-port synchronous RAM with a hardware clear sweep.
//
// One write port and one registered read port share a single clock. After
// reset, or when init_req is seen while idle, a sequencer writes INIT_VAL to
// every word (one word per cycle). User accesses are ignored while it runs, so
// nothing downstream can observe stale contents.
//
// Parameters
//   DATA_W    word width in bits
//   ADDR_W    address width in bits
//   DEPTH     number of words, 1..2**ADDR_W
//   RDW_MODE  same-address read during write: 0 = old data, 1 = new data
//   INIT_VAL  value written to every word by the clear sweep
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   we          in   write enable
//   write_addr  in   write address (ADDR_W)
//   data        in   write data (DATA_W)
//   re          in   read enable
//   read_addr   in   read address (ADDR_W)
//   q           out  registered read data (DATA_W)
//   q_valid     out  one-cycle pulse per accepted read
//   init_req    in   start a new clear sweep (only honoured while READY)
//   init_busy   out  clear sweep in progress
//   dbg_state   out  FSM state: 0 = INIT, 1 = READY
//
// Optional feature (macro RAM_PARITY_EN)
//   Each word carries an extra even-parity bit.
//   err_inject  in   with we, stores the inverted parity bit
//   parity_err  out  valid with q_valid: stored parity disagrees with word
//
// Handshake: there is no backpressure. A write is accepted on any rising edge
// where the FSM is READY, we=1 and write_addr<DEPTH. A read is accepted on any
// rising edge where the FSM is READY and re=1; its result appears on q with
// q_valid=1 right after that edge (latency 1). Out-of-range reads return 0.

module ram_sdp_init #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                DEPTH    = 64,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] data,
  input  logic              re,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  input  logic              init_req,
  output logic              init_busy,
`ifdef RAM_PARITY_EN
  input  logic              err_inject,
  output logic              parity_err,
`endif
  output logic              dbg_state
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // Index width into the physical array; DEPTH <= 2**ADDR_W so IDX_W <= ADDR_W.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH may equal 2**ADDR_W, so range checks use one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              parity_err_q, parity_err_d;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              user_we;
  logic [MEM_W-1:0]  user_word;
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  rd_word;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;

  assign wr_in_range = ({1'b0, write_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_L);
  assign user_we     = we && wr_in_range;

  // Stored word layout: parity bit (if present) above the data bits.
`ifdef RAM_PARITY_EN
  assign user_word = {(^data) ^ err_inject, data};
  assign init_word = {^INIT_VAL, INIT_VAL};
`else
  assign user_word = data;
  assign init_word = INIT_VAL;
`endif

  // Array read with optional write-first bypass. In read-first mode the array
  // is read before the same-edge write lands, which yields the old word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[read_addr[IDX_W-1:0]];
      if ((RDW_MODE == 1) && user_we && (write_addr == read_addr)) begin
        rd_word = user_word;
      end
    end
  end

  // Next-state, write-port mux and read result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_d          = q_q;
    q_valid_d    = 1'b0;
    parity_err_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = write_addr;
    mem_wdata    = user_word;

    case (state_q)
      ST_INIT: begin
        // Sweep owns the write port; user reads are ignored and q holds.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = init_word;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      ST_READY: begin
        mem_we = user_we;
        if (re) begin
          q_valid_d = 1'b1;
          q_d       = rd_word[DATA_W-1:0];
`ifdef RAM_PARITY_EN
          // Out-of-range reads return an all-zero word, which is never an error.
          parity_err_d = rd_in_range && (rd_word[DATA_W] != (^rd_word[DATA_W-1:0]));
`endif
        end
        // The access in this same cycle still completes before the sweep starts.
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      q_q          <= '0;
      q_valid_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      q_q          <= q_d;
      q_valid_q    <= q_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Array storage carries no reset; the sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  assign q         = q_q;
  assign q_valid   = q_valid_q;
  assign init_busy = (state_q == ST_INIT);
  assign dbg_state = state_q;

`ifdef RAM_PARITY_EN
  assign parity_err = parity_err_q;
`else
  // Parity register is unused when storage carries no parity bit.
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule
